wb_arbiter_2to1: RTL and testbench

Two-master, one-slave Wishbone B4 arbiter that shares the simulation RAM data port (or any single B4 slave) between the core's instruction master (m0) and data master (m1). It holds a grant for the whole bus cycle, so incrementing or wrapping bursts are never split. Arbitration is round-robin or fixed-priority, selected by parameter. A stall watchdog aborts a hung transfer with an error pulse to the owning master.

---
 rtl/wb_arbiter_2to1.sv | 156 +++++++++++++++
 tb/tb_wb_arbiter_2to1.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2to1.sv
// Two-master, one-slave Wishbone B4 arbiter. A grant is held for the whole bus cycle,
// and a stall watchdog aborts a hung transfer with an error pulse.
module wb_arbiter_2to1 #(
  parameter int FAIR    = 1,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_dat_w,
  input  logic [3:0]  m0_sel,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic [2:0]  m0_cti,
  input  logic [1:0]  m0_bte,
  input  logic        m0_we,
  output logic [31:0] m0_dat_r,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_dat_w,
  input  logic [3:0]  m1_sel,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic [2:0]  m1_cti,
  input  logic [1:0]  m1_bte,
  input  logic        m1_we,
  output logic [31:0] m1_dat_r,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] s_addr,
  output logic [31:0] s_dat_w,
  output logic [3:0]  s_sel,
  output logic        s_cyc,
  output logic        s_stb,
  output logic [2:0]  s_cti,
  output logic [1:0]  s_bte,
  output logic        s_we,
  input  logic [31:0] s_dat_r,
  input  logic        s_ack
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  localparam logic [15:0] TO    = TIMEOUT[15:0];
  localparam bit          WD_EN = (TIMEOUT != 0);

  state_t      state, state_nxt;
  logic        last, last_nxt;
  logic        owner, owner_nxt;
  logic [15:0] cnt, cnt_nxt;

  logic gx, cyc_x, stb_x, own_cyc, any_req, pick;

  // Ties go to the master that was not granted last, or always to m1 when not fair.
  function automatic logic arb(input logic c0, input logic c1, input logic lst);
    if (c0 && !c1) return 1'b0;
    if (c1 && !c0) return 1'b1;
    if (FAIR != 0) return ~lst;
    return 1'b1;
  endfunction

  assign gx       = (state == GNT1);
  assign cyc_x    = gx ? m1_cyc : m0_cyc;
  assign stb_x    = gx ? m1_stb : m0_stb;
  assign own_cyc  = owner ? m1_cyc : m0_cyc;
  assign any_req  = m0_cyc | m1_cyc;
  assign pick     = arb(m0_cyc, m1_cyc, last);
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    owner_nxt = owner;
    cnt_nxt   = '0;
    s_addr    = '0;
    s_dat_w   = '0;
    s_sel     = '0;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_cti     = '0;
    s_bte     = '0;
    s_we      = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = pick ? GNT1 : GNT0;
          last_nxt  = pick;
        end
      end
      GNT0, GNT1: begin
        s_addr  = gx ? m1_addr  : m0_addr;
        s_dat_w = gx ? m1_dat_w : m0_dat_w;
        s_sel   = gx ? m1_sel   : m0_sel;
        s_cyc   = cyc_x;
        s_stb   = stb_x;
        s_cti   = gx ? m1_cti   : m0_cti;
        s_bte   = gx ? m1_bte   : m0_bte;
        s_we    = gx ? m1_we    : m0_we;
        if (gx) m1_ack = s_ack;
        else    m0_ack = s_ack;
        // A late ack in the expiry cycle still completes the transfer.
        if (WD_EN && cnt == TO && !s_ack) begin
          s_cyc     = 1'b0;
          s_stb     = 1'b0;
          m0_ack    = 1'b0;
          m1_ack    = 1'b0;
          m0_err    = ~gx;
          m1_err    = gx;
          owner_nxt = gx;
          state_nxt = ABORT;
        end else if (!cyc_x) begin
          if (any_req) begin
            state_nxt = pick ? GNT1 : GNT0;
            last_nxt  = pick;
          end else begin
            state_nxt = IDLE;
          end
        end else if (WD_EN && stb_x && !s_ack) begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          if (any_req) begin
            state_nxt = pick ? GNT1 : GNT0;
            last_nxt  = pick;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Bench for wb_arbiter_2to1: a round-robin/watchdog instance and a fixed-priority instance
// share the same master and slave stimulus and are compared against a transaction-level model.
module tb_wb_arbiter_2to1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][31:0] m_addr, m_dat_w;
  logic [1:0][3:0]  m_sel;
  logic [1:0]       m_cyc, m_stb, m_we;
  logic [1:0][2:0]  m_cti;
  logic [1:0][1:0]  m_bte;
  logic [31:0]      s_dat_r;
  logic             s_ack;

  logic [1:0][31:0] m0_dat_r, m1_dat_r, s_addr, s_dat_w;
  logic [1:0]       m0_ack, m1_ack, m0_err, m1_err, s_cyc, s_stb, s_we;
  logic [1:0][3:0]  s_sel;
  logic [1:0][2:0]  s_cti;
  logic [1:0][1:0]  s_bte;

  logic [31:0] ram [0:1023];
  assign s_dat_r = ram[s_addr[0][11:2]];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_arbiter_2to1 #(.FAIR(g == 0 ? 1 : 0), .TIMEOUT(g == 0 ? 8 : 0)) u_dut (
      .clk(clk), .rst(rst),
      .m0_addr(m_addr[0]), .m0_dat_w(m_dat_w[0]), .m0_sel(m_sel[0]), .m0_cyc(m_cyc[0]),
      .m0_stb(m_stb[0]), .m0_cti(m_cti[0]), .m0_bte(m_bte[0]), .m0_we(m_we[0]),
      .m0_dat_r(m0_dat_r[g]), .m0_ack(m0_ack[g]), .m0_err(m0_err[g]),
      .m1_addr(m_addr[1]), .m1_dat_w(m_dat_w[1]), .m1_sel(m_sel[1]), .m1_cyc(m_cyc[1]),
      .m1_stb(m_stb[1]), .m1_cti(m_cti[1]), .m1_bte(m_bte[1]), .m1_we(m_we[1]),
      .m1_dat_r(m1_dat_r[g]), .m1_ack(m1_ack[g]), .m1_err(m1_err[g]),
      .s_addr(s_addr[g]), .s_dat_w(s_dat_w[g]), .s_sel(s_sel[g]), .s_cyc(s_cyc[g]),
      .s_stb(s_stb[g]), .s_cti(s_cti[g]), .s_bte(s_bte[g]), .s_we(s_we[g]),
      .s_dat_r(s_dat_r), .s_ack(s_ack)
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: who holds the bus (-1 = nobody), pending abort, stall length.
  int  g_gnt [2];
  bit  g_abrt [2];
  bit  g_own [2];
  bit  g_last [2];
  int  g_cnt [2];
  bit          wr_pend;
  logic [9:0]  wr_idx;
  logic [31:0] wr_dat;

  function automatic int to_of(input int i);
    return (i == 0) ? 8 : 0;
  endfunction

  function automatic int pick(input int i);
    if (m_cyc[0] && !m_cyc[1]) return 0;
    if (m_cyc[1] && !m_cyc[0]) return 1;
    if (i == 0) return g_last[i] ? 0 : 1;
    return 1;
  endfunction

  task automatic model_reset(input int i);
    g_gnt[i] = -1; g_abrt[i] = 1'b0; g_own[i] = 1'b0; g_last[i] = 1'b1; g_cnt[i] = 0;
  endtask

  task automatic grant(input int i);
    int n;
    n = pick(i);
    g_gnt[i] = n;
    g_last[i] = (n == 1);
  endtask

  task automatic model_cycle(input int i);
    logic [75:0] es, got;
    logic [1:0]  ea, ee;
    int x;
    bit req;
    es = '0; ea = '0; ee = '0;
    req = m_cyc[0] | m_cyc[1];
    if (rst) begin
      model_reset(i);
    end else if (g_gnt[i] >= 0) begin
      x = g_gnt[i];
      es = {m_addr[x], m_dat_w[x], m_sel[x], m_cyc[x], m_stb[x], m_cti[x], m_bte[x], m_we[x]};
      ea[x] = s_ack;
      if (to_of(i) != 0 && g_cnt[i] == to_of(i) && !s_ack) begin
        es[7:6] = 2'b00; ea = '0; ee[x] = 1'b1;
        g_own[i] = (x == 1); g_gnt[i] = -1; g_abrt[i] = 1'b1; g_cnt[i] = 0;
      end else if (!m_cyc[x]) begin
        g_cnt[i] = 0;
        if (req) grant(i); else g_gnt[i] = -1;
      end else begin
        if (to_of(i) != 0 && m_stb[x] && !s_ack) g_cnt[i]++; else g_cnt[i] = 0;
        if (i == 0 && m_stb[x] && s_ack && m_we[x]) begin
          wr_pend = 1'b1; wr_idx = m_addr[x][11:2]; wr_dat = m_dat_w[x];
        end
      end
    end else if (g_abrt[i]) begin
      if (!m_cyc[g_own[i]]) begin
        g_abrt[i] = 1'b0;
        if (req) grant(i);
      end
    end else if (req) begin
      grant(i);
    end
    got = {s_addr[i], s_dat_w[i], s_sel[i], s_cyc[i], s_stb[i], s_cti[i], s_bte[i], s_we[i]};
    check($sformatf("bus%0d", i), got, es);
    check($sformatf("ack%0d", i), {m1_ack[i], m0_ack[i]}, ea);
    check($sformatf("err%0d", i), {m1_err[i], m0_err[i]}, ee);
    check($sformatf("dat_r%0d", i), {m1_dat_r[i], m0_dat_r[i]}, {s_dat_r, s_dat_r});
  endtask

  task automatic step();
    #1;
    for (int i = 0; i < 2; i++) model_cycle(i);
    if (wr_pend) begin
      ram[wr_idx] = wr_dat;
      wr_pend = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_addr = '0; m_dat_w = '0; m_sel = '0; m_cyc = '0; m_stb = '0;
    m_we = '0; m_cti = '0; m_bte = '0; s_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int acks0, acks1, n_m0, n_m1, stall;

  initial begin
    for (int k = 0; k < 1024; k++) ram[k] = '0;
    wr_pend = 1'b0; wr_idx = '0; wr_dat = '0;
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) model_reset(i);
    @(posedge clk);
    #1;
    step();
    check("rst_scyc", s_cyc, 2'b00);
    check("rst_ack", {m1_ack, m0_ack}, 4'h0);
    check("rst_err", {m1_err, m0_err}, 4'h0);
    rst = 1'b0;
    step();

    // Single-master classic read
    ram[10'h40] = 32'hDEADBEEF;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 32'h100; m_sel[0] = 4'hF;
    #1; check("rd_lat0", s_cyc[0], 1'b0);
    step();
    #1; check("rd_lat1", s_cyc[0], 1'b1);
    step();
    s_ack = 1'b1;
    #1;
    check("rd_ack", m0_ack[0], 1'b1);
    check("rd_data", m0_dat_r[0], 32'hDEADBEEF);
    check("rd_m1ack", m1_ack[0], 1'b0);
    step();
    idle_inputs();
    step();

    // Tie after reset, handoff, and second tie
    do_reset();
    m_addr[0] = 32'h1000; m_addr[1] = 32'h2000;
    m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
    step();
    #1;
    check("tie0_rr", s_addr[0], 32'h1000);
    check("tie0_fp", s_addr[1], 32'h2000);
    step();
    step();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1; check("hand_gap", s_cyc[0], 1'b0);
    step();
    #1;
    check("hand_m1", s_addr[0], 32'h2000);
    check("hand_cyc", s_cyc[0], 1'b1);
    step();
    m_cyc = 2'b00; m_stb = 2'b00;
    step();
    step();
    m_cyc = 2'b11; m_stb = 2'b11;
    step();
    #1; check("tie1_rr", s_addr[0], 32'h1000);
    step();
    m_cyc = 2'b00; m_stb = 2'b00;
    step();
    step();

    // Burst lock: m1 4-beat incrementing write, m0 requests at beat 2
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_sel[1] = 4'hF;
    m_addr[1] = 32'h200; m_cti[1] = 3'b010; m_bte[1] = 2'b00; s_ack = 1'b0;
    step();
    s_ack = 1'b1; acks0 = 0; acks1 = 0;
    for (int b = 0; b < 4; b++) begin
      m_addr[1] = 32'h200 + 32'(4 * b);
      m_dat_w[1] = 32'hA5A50000 + 32'(b);
      m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
      if (b == 1) begin
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 32'h300; m_we[0] = 1'b0;
      end
      #1;
      acks0 += int'(m0_ack[0]);
      acks1 += int'(m1_ack[0]);
      step();
    end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0; s_ack = 1'b0;
    #1; check("burst_rel", s_cyc[0], 1'b0);
    step();
    #1;
    check("burst_m0", s_addr[0], 32'h300);
    check("burst_m0cyc", s_cyc[0], 1'b1);
    step();
    check("burst_acks1", acks1, 4);
    check("burst_acks0", acks0, 0);
    idle_inputs();
    step();
    for (int b = 0; b < 4; b++) check($sformatf("ram%0d", b), ram[10'h80 + 10'(b)], 32'hA5A50000 + 32'(b));

    // Watchdog: slave never acks, m0 owns the bus, m1 waits
    do_reset();
    m_addr[0] = 32'h1000; m_addr[1] = 32'h2000;
    m_cyc = 2'b11; m_stb = 2'b01; s_ack = 1'b0;
    step();
    for (int t = 0; t < 12; t++) begin
      #1;
      check($sformatf("wd_err_t%0d", t), m0_err[0], (t == 8));
      check($sformatf("wd_cyc_t%0d", t), s_cyc[0], (t < 8));
      step();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1; check("wd_hold", s_cyc[0], 1'b0);
    step();
    #1;
    check("wd_m1", s_addr[0], 32'h2000);
    check("wd_m1cyc", s_cyc[0], 1'b1);
    step();
    idle_inputs();
    step();

    // Back-to-back cycles from both masters: fixed priority never grants m0 on a tie
    m_addr[0] = 32'h1000; m_addr[1] = 32'h2000; s_ack = 1'b1; n_m0 = 0; n_m1 = 0;
    for (int c = 0; c < 40; c++) begin
      m_cyc = ((c % 4) != 3) ? 2'b11 : 2'b00;
      m_stb = m_cyc;
      #1;
      if (s_cyc[1] && s_addr[1] == 32'h1000) n_m0++;
      if (s_cyc[1] && s_addr[1] == 32'h2000) n_m1++;
      step();
    end
    check("fp_m0_gnt", n_m0, 0);
    check("fp_m1_gnt", n_m1, 20);

    // Asynchronous reset during beat 2 of an m1 burst
    idle_inputs();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_addr[1] = 32'h2000; m_cti[1] = 3'b010; s_ack = 1'b1;
    step();
    step();
    #2;
    check("ar_pre_ack", m1_ack[0], 1'b1);
    rst = 1'b1;
    #1;
    check("ar_scyc", s_cyc[0], 1'b0);
    check("ar_sstb", s_stb[0], 1'b0);
    check("ar_ack", m1_ack[0], 1'b0);
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    m_addr[0] = 32'h1000; m_cyc = 2'b11; m_stb = 2'b11;
    step();
    #1; check("ar_tie", s_addr[0], 32'h1000);
    step();
    idle_inputs();
    step();

    // Randomized traffic with occasional long slave stalls
    do_reset();
    stall = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!m_cyc[m]) begin
          if ($urandom_range(3) == 0) m_cyc[m] = 1'b1;
        end else if ($urandom_range(7) == 0) begin
          m_cyc[m] = 1'b0;
        end
        m_stb[m] = m_cyc[m] && ($urandom_range(3) != 0);
        m_addr[m] = 32'($urandom_range(1023)) << 2;
        m_dat_w[m] = $urandom;
        m_sel[m] = 4'($urandom);
        m_cti[m] = 3'($urandom);
        m_bte[m] = 2'($urandom);
        m_we[m] = 1'($urandom);
      end
      if (stall > 0) begin
        s_ack = 1'b0;
        stall--;
      end else begin
        if ($urandom_range(60) == 0) stall = 14;
        s_ack = 1'($urandom);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
